tick_countdown_timer: RTL and testbench
=======================================

Name: tick_countdown_timer

Overview:
Consumer-side partner of the 1 ms tick generator. It takes the generator's single-cycle tick pulse and counts a loaded duration down in tick units, one unit per tick. It reports the remaining time, a run/pause state and a single-cycle expiry pulse. Software-style control (load/start/pause/clear) comes from the top-level FSM or the button/switch logic.

Parameters:
W, 10, width of duration/remaining value in ticks (max 1023 ms at 1 ms tick)
CW, 8, width of expiry event counter

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous active-low reset (asserted when 0)
tick  input  1  tick pulse from generator; each cycle it is high counts as one tick
load  input  1  capture load_val into remaining and shadow register
load_val  input  W  duration in ticks
start  input  1  begin/resume countdown
pause  input  1  freeze countdown
clear  input  1  synchronous abort to IDLE
remaining  output  W  ticks left
busy  output  1  high in RUN or PAUSED
done  output  1  level, high in DONE
expired  output  1  one-cycle pulse on reaching zero
expire_cnt  output  CW  number of expiries since reset/clear, wraps modulo 2^CW
state  output  2  IDLE=00, RUN=01, PAUSED=10, DONE=11

Behaviour:
- Reset (rst=0, async): state=IDLE, remaining=0, shadow=0, expired=0, expire_cnt=0. busy=0, done=0.
- All outputs are registered. busy and done are decoded from the state register.
- Same-cycle priority: clear > load > start > pause > tick.
- clear, any state: next cycle state=IDLE, remaining=0, expired=0, expire_cnt=0. Shadow is kept.
- IDLE:
  - load: remaining<=load_val and shadow<=load_val.
  - start with remaining!=0: go to RUN.
  - start with remaining==0: go to DONE, with expired=1 for one cycle and expire_cnt+1.
  - tick and pause are ignored.
- RUN:
  - tick with remaining>1: remaining-1.
  - tick with remaining==1: remaining<=0, state<=DONE, expired=1 on the same edge, expire_cnt+1.
  - pause: go to PAUSED with no decrement that cycle, even if tick is high.
  - load: ignored.
  - start: no effect.
- PAUSED:
  - tick is ignored.
  - start: go to RUN; decrementing resumes on the next tick after the transition.
  - load: update remaining and shadow, stay in PAUSED.
- DONE:
  - remaining holds 0.
  - start: remaining<=shadow and state<=RUN. If shadow==0, stay in DONE and pulse expired again.
  - load: update remaining and shadow, go to IDLE.
  - tick and pause are ignored.
- Latency:
  - expired asserts on the clock edge that consumes the final tick, so it is visible the cycle after that tick input.
  - expired deasserts on the next cycle.
- Tick held high for k cycles in RUN counts as k ticks.
- Arithmetic: remaining never underflows; the decrement is gated by remaining!=0. expire_cnt wraps 2^CW-1 -> 0.
- Reset mid-count: everything returns to reset values immediately, with no expired pulse.

Optional Feature:
Macro AUTO_RELOAD_EN.
- Defined: on expiry in RUN, remaining<=shadow, state stays RUN, expired pulses and expire_cnt increments. This produces a periodic expired pulse every shadow ticks. DONE is reachable only through start with remaining==0 or shadow==0. pause and clear act as normal.
- Undefined: behaviour is exactly as in the Behaviour section, with expiry going to DONE.

Test Plan:
- Reset with rst=0 mid-RUN, remaining=7 -> remaining=0, state=00, expired=0, expire_cnt=0 asynchronously; no pulse after release.
- load_val=5, load, start, then 5 ticks spaced 3 cycles apart -> remaining 5,4,3,2,1,0; expired high exactly 1 cycle after the 5th tick; state=11, done=1, expire_cnt=1.
- load 4, start, 1 tick (remaining=3), pause with tick high the same cycle -> remaining stays 3; 10 ticks while PAUSED -> still 3; start then 3 ticks -> expired, DONE.
- clear and tick asserted together in RUN with remaining=1 -> IDLE, remaining=0, no expired, expire_cnt=0.
- Load 0, start -> DONE next cycle, expired one-cycle pulse, expire_cnt=1. In DONE, start with shadow=0 -> another pulse, expire_cnt=2.
- AUTO_RELOAD_EN defined, load 3, start, tick held continuously for 9 cycles -> expired pulses after ticks 3, 6 and 9; state stays 01; expire_cnt=3. With CW=8, 256 expiries -> expire_cnt wraps to 0.

Source files
------------

// File: rtl/tick_countdown_timer.sv
// -----------------------------------------------------------------------------
// tick_countdown_timer
//
// Purpose:
//   Consumer-side partner of the 1 ms tick generator. A duration (in ticks) is
//   loaded into 'remaining' and into a shadow register. Each tick pulse while
//   running takes one unit off 'remaining'. When the last unit is consumed, a
//   single-cycle 'expired' pulse is produced and the expiry event counter
//   advances.
//
// Optional feature (compile-time macro AUTO_RELOAD_EN):
//   When the macro is defined, an expiry in RUN reloads 'remaining' from the
//   shadow register and stays in RUN. This gives a periodic 'expired' pulse
//   every <shadow> ticks. When it is undefined, expiry moves to DONE.
//
// Parameters:
//   W   width of the duration / remaining value in ticks
//   CW  width of the expiry event counter (wraps modulo 2^CW)
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   rst         asynchronous reset, active low
//   tick        one-cycle tick pulse; every high cycle counts as one tick
//   load        capture load_val into remaining and shadow
//   load_val    duration in ticks
//   start       begin or resume the countdown
//   pause       freeze the countdown
//   clear       synchronous abort to IDLE (shadow is kept)
//   remaining   ticks left
//   busy        high in RUN or PAUSED
//   done        high in DONE
//   expired     one-cycle pulse when the count reaches zero
//   expire_cnt  number of expiries since reset or clear
//   state       IDLE=00, RUN=01, PAUSED=10, DONE=11
//
// Same-cycle priority: clear > load > start > pause > tick. An input that a
// state ignores is treated as absent, so it does not mask a lower-priority
// input in that state (e.g. load in RUN does not stop a tick from counting).
// -----------------------------------------------------------------------------
module tick_countdown_timer #(
  parameter int W  = 10,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          load,
  input  logic [W-1:0]  load_val,
  input  logic          start,
  input  logic          pause,
  input  logic          clear,
  output logic [W-1:0]  remaining,
  output logic          busy,
  output logic          done,
  output logic          expired,
  output logic [CW-1:0] expire_cnt,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t          state_reg;
  logic [W-1:0]    remaining_reg;
  logic [W-1:0]    shadow_reg;
  logic            expired_reg;
  logic [CW-1:0]   expire_cnt_reg;

  // Single registered FSM. 'expired' defaults low every cycle so that any
  // branch setting it produces exactly a one-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      remaining_reg  <= '0;
      shadow_reg     <= '0;
      expired_reg    <= 1'b0;
      expire_cnt_reg <= '0;
    end else begin
      expired_reg <= 1'b0;

      if (clear) begin
        // Abort: counters reset, shadow deliberately retained so a later
        // start from DONE can still reuse the last duration.
        state_reg      <= IDLE;
        remaining_reg  <= '0;
        expire_cnt_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (load) begin
              remaining_reg <= load_val;
              shadow_reg    <= load_val;
            end else if (start) begin
              if (remaining_reg != '0) begin
                state_reg <= RUN;
              end else begin
                // Zero-length countdown expires immediately.
                state_reg      <= DONE;
                expired_reg    <= 1'b1;
                expire_cnt_reg <= expire_cnt_reg + CW'(1);
              end
            end
          end

          RUN: begin
            // load and start have no effect here; pause beats tick so the
            // cycle that pauses never decrements.
            if (pause) begin
              state_reg <= PAUSED;
            end else if (tick && (remaining_reg != '0)) begin
              if (remaining_reg == W'(1)) begin
                expired_reg    <= 1'b1;
                expire_cnt_reg <= expire_cnt_reg + CW'(1);
`ifdef AUTO_RELOAD_EN
                remaining_reg  <= shadow_reg;
`else
                remaining_reg  <= '0;
                state_reg      <= DONE;
`endif
              end else begin
                remaining_reg <= remaining_reg - W'(1);
              end
            end
          end

          PAUSED: begin
            if (load) begin
              remaining_reg <= load_val;
              shadow_reg    <= load_val;
            end else if (start) begin
              // The resume edge itself does not count a tick; the next one does.
              state_reg <= RUN;
            end
          end

          DONE: begin
            if (load) begin
              remaining_reg <= load_val;
              shadow_reg    <= load_val;
              state_reg     <= IDLE;
            end else if (start) begin
              if (shadow_reg == '0) begin
                // Restarting a zero duration expires again straight away.
                expired_reg    <= 1'b1;
                expire_cnt_reg <= expire_cnt_reg + CW'(1);
              end else begin
                remaining_reg <= shadow_reg;
                state_reg     <= RUN;
              end
            end
          end

          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign remaining  = remaining_reg;
  assign expired    = expired_reg;
  assign expire_cnt = expire_cnt_reg;
  assign state      = state_reg;
  assign busy       = (state_reg == RUN) || (state_reg == PAUSED);
  assign done       = (state_reg == DONE);

endmodule

// File: tb/tb_tick_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_tick_countdown_timer
//
// Directed bench for tick_countdown_timer. Inputs change 1 ns after the rising
// edge and outputs are sampled at the same point, i.e. after each edge has
// settled. With AUTO_RELOAD_EN defined the periodic-reload sequence replaces
// the run-to-DONE sequences; the zero-duration, wrap and reset steps are common.
// -----------------------------------------------------------------------------
module tb_tick_countdown_timer;

  localparam int W  = 10;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          tick;
  logic          load;
  logic [W-1:0]  load_val;
  logic          start;
  logic          pause;
  logic          clear;
  logic [W-1:0]  remaining;
  logic          busy;
  logic          done;
  logic          expired;
  logic [CW-1:0] expire_cnt;
  logic [1:0]    state;

  int tests_run;
  int tests_failed;

  tick_countdown_timer #(.W(W), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .load       (load),
    .load_val   (load_val),
    .start      (start),
    .pause      (pause),
    .clear      (clear),
    .remaining  (remaining),
    .busy       (busy),
    .done       (done),
    .expired    (expired),
    .expire_cnt (expire_cnt),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst      = 1'b0;
    tick     = 1'b0;
    load     = 1'b0;
    load_val = '0;
    start    = 1'b0;
    pause    = 1'b0;
    clear    = 1'b0;

    // ---------------- reset state ----------------
    cyc(); cyc();
    check("rst_state", 32'(state), 0);
    check("rst_remaining", 32'(remaining), 0);
    check("rst_expired", 32'(expired), 0);
    check("rst_cnt", 32'(expire_cnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst = 1'b1;
    cyc();
    $display("[TB] reset released");

`ifdef AUTO_RELOAD_EN
    // ---------------- periodic reload ----------------
    load_val = 10'd3; load = 1'b1; cyc(); load = 1'b0;
    check("ar_load", 32'(remaining), 3);
    start = 1'b1; cyc(); start = 1'b0;
    check("ar_run", 32'(state), 1);
    tick = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      $display("[TB] autoreload tick %0d remaining=%0d expired=%0d cnt=%0d", k, remaining, expired, expire_cnt);
      check("ar_remaining", 32'(remaining), (k % 3 == 0) ? 3 : 3 - (k % 3));
      check("ar_expired", 32'(expired), (k % 3 == 0) ? 1 : 0);
      check("ar_state", 32'(state), 1);
      check("ar_cnt", 32'(expire_cnt), k / 3);
    end
    tick = 1'b0;
    cyc();
    check("ar_expired_low", 32'(expired), 0);
`else
    // ---------------- load 5, 5 spaced ticks ----------------
    load_val = 10'd5; load = 1'b1; cyc(); load = 1'b0;
    check("l5_remaining", 32'(remaining), 5);
    check("l5_state", 32'(state), 0);
    start = 1'b1; cyc(); start = 1'b0;
    check("l5_run", 32'(state), 1);
    check("l5_busy", 32'(busy), 1);
    check("l5_remaining_run", 32'(remaining), 5);
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      $display("[TB] tick %0d remaining=%0d expired=%0d state=%0d", i + 1, remaining, expired, state);
      check("l5_tick_remaining", 32'(remaining), 4 - i);
      check("l5_tick_expired", 32'(expired), (i == 4) ? 1 : 0);
      if (i == 4) begin
        check("l5_done_state", 32'(state), 3);
        check("l5_done", 32'(done), 1);
        check("l5_busy_low", 32'(busy), 0);
        check("l5_cnt", 32'(expire_cnt), 1);
      end
      cyc();
      check("l5_gap_expired", 32'(expired), 0);
      cyc();
    end

    // ---------------- pause / resume ----------------
    load_val = 10'd4; load = 1'b1; cyc(); load = 1'b0;
    check("p_load_idle", 32'(state), 0);
    check("p_load_remaining", 32'(remaining), 4);
    start = 1'b1; cyc(); start = 1'b0;
    tick = 1'b1; cyc();
    check("p_first_tick", 32'(remaining), 3);
    pause = 1'b1; cyc(); pause = 1'b0;
    check("p_paused_state", 32'(state), 2);
    check("p_no_dec", 32'(remaining), 3);
    for (int i = 0; i < 10; i++) cyc();
    check("p_ticks_ignored", 32'(remaining), 3);
    check("p_still_paused", 32'(state), 2);
    check("p_busy", 32'(busy), 1);
    tick = 1'b0; start = 1'b1; cyc(); start = 1'b0;
    check("p_resume_state", 32'(state), 1);
    check("p_resume_remaining", 32'(remaining), 3);
    tick = 1'b1;
    cyc(); check("p_r2", 32'(remaining), 2);
    cyc(); check("p_r1", 32'(remaining), 1);
    cyc();
    $display("[TB] pause test end remaining=%0d expired=%0d state=%0d", remaining, expired, state);
    check("p_r0", 32'(remaining), 0);
    check("p_expired", 32'(expired), 1);
    check("p_done", 32'(state), 3);
    check("p_cnt", 32'(expire_cnt), 2);
    tick = 1'b0; cyc();
    check("p_expired_low", 32'(expired), 0);

    // ---------------- restart from DONE, then clear at remaining 1 ----------------
    start = 1'b1; cyc(); start = 1'b0;
    check("rs_state", 32'(state), 1);
    check("rs_remaining", 32'(remaining), 4);
    tick = 1'b1; cyc(); cyc(); cyc();
    check("c_remaining1", 32'(remaining), 1);
    clear = 1'b1; cyc(); clear = 1'b0; tick = 1'b0;
    $display("[TB] clear state=%0d remaining=%0d expired=%0d cnt=%0d", state, remaining, expired, expire_cnt);
    check("c_state", 32'(state), 0);
    check("c_remaining", 32'(remaining), 0);
    check("c_expired", 32'(expired), 0);
    check("c_cnt", 32'(expire_cnt), 0);
`endif

    // ---------------- zero-length duration and counter wrap ----------------
    clear = 1'b1; cyc(); clear = 1'b0;
    load_val = 10'd0; load = 1'b1; cyc(); load = 1'b0;
    check("z_remaining", 32'(remaining), 0);
    start = 1'b1; cyc(); start = 1'b0;
    check("z_state", 32'(state), 3);
    check("z_expired", 32'(expired), 1);
    check("z_cnt", 32'(expire_cnt), 1);
    cyc();
    check("z_expired_low", 32'(expired), 0);
    check("z_done", 32'(done), 1);
    start = 1'b1; cyc();
    check("z2_expired", 32'(expired), 1);
    check("z2_cnt", 32'(expire_cnt), 2);
    check("z2_state", 32'(state), 3);
    for (int k = 1; k <= 255; k++) begin
      cyc();
      if (k == 253) check("w_cnt255", 32'(expire_cnt), 255);
      if (k == 254) check("w_cnt_wrap", 32'(expire_cnt), 0);
    end
    $display("[TB] wrap cnt=%0d expired=%0d", expire_cnt, expired);
    check("w_cnt1", 32'(expire_cnt), 1);
    check("w_expired", 32'(expired), 1);
    start = 1'b0; cyc();
    check("w_expired_low", 32'(expired), 0);

    // ---------------- asynchronous reset mid-RUN ----------------
    load_val = 10'd7; load = 1'b1; cyc(); load = 1'b0;
    check("ar7_idle", 32'(state), 0);
    start = 1'b1; cyc(); start = 1'b0;
    check("ar7_run", 32'(state), 1);
    check("ar7_remaining", 32'(remaining), 7);
    #2 rst = 1'b0;
    #1;
    $display("[TB] async reset state=%0d remaining=%0d cnt=%0d", state, remaining, expire_cnt);
    check("ares_state", 32'(state), 0);
    check("ares_remaining", 32'(remaining), 0);
    check("ares_cnt", 32'(expire_cnt), 0);
    check("ares_expired", 32'(expired), 0);
    tick = 1'b1; cyc();
    rst = 1'b1;
    cyc(); cyc(); cyc();
    check("post_state", 32'(state), 0);
    check("post_expired", 32'(expired), 0);
    check("post_remaining", 32'(remaining), 0);
    check("post_cnt", 32'(expire_cnt), 0);
    tick = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
